// File: rtl/arbiter_client.sv
// arbiter_client
//   Requester-side endpoint of the token-ring req/ack handshake. Incoming
//   jobs (each a beat count minus one) are queued in a small circular FIFO.
//   The head job is popped when the slot is free, `req` is raised, and once
//   `ack` is seen the slot is held for job_len+1 beats. The block then drops
//   `req` and waits for `ack` to fall before it starts the next job.
//
// Parameters
//   DEPTH  queue entries (power of 2, >= 2)
//   LEN_W  width of the job length field
//
// Ports
//   clk        clock, all state changes on posedge
//   reset      synchronous active-high; clears queue pointers and FSM
//   job_valid  job offered this cycle
//   job_len    offered job length (beats - 1)
//   job_ready  queue can accept a job (not full)
//   req        registered request to the ring controller
//   ack        grant from the ring controller
//   beat       slot held this cycle
//   done       last beat of the current job
//   pending    jobs queued, excluding the one in service
module arbiter_client #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     job_valid,
  input  logic [LEN_W-1:0]         job_len,
  output logic                     job_ready,
  output logic                     req,
  input  logic                     ack,
  output logic                     beat,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_RELEASE
  } state_t;

  logic [LEN_W-1:0] queue_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [LEN_W-1:0] beats_left;
  state_t           state;
  logic             full;
  logic             push;
  logic             pop;

  assign full      = (count == FULL_CNT);
  assign job_ready = !full;
  assign pending   = count;
  assign push      = job_valid && !full;
  // A pop is the IDLE->REQ transition itself; it also requires ack low so
  // that req never rises while the controller is still granting.
  assign pop       = (state == S_IDLE) && (count != '0) && !ack;

  assign beat = (state == S_HOLD);
  assign done = (state == S_HOLD) && (beats_left == '0);

  // Queue control: pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries data only; stale entries are unreachable after
  // reset because the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= job_len;
  end

  // Handshake FSM. req is a flop; beats_left is data and is only loaded on
  // a pop, so it is left out of the reset branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      req   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            beats_left <= queue_mem[rd_ptr];
            req        <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack) state <= S_HOLD;
        end
        S_HOLD: begin
          // An ack drop here is a controller fault; the job runs to completion.
          if (beats_left == '0) begin
            req   <= 1'b0;
            state <= S_RELEASE;
          end else begin
            beats_left <= beats_left - 1'b1;
          end
        end
        S_RELEASE: begin
          if (!ack) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_client.sv
// tb_arbiter_client
//   Directed bench for arbiter_client (DEPTH=4, LEN_W=4). The bench plays
//   the ring controller by driving ack by hand and checks queue occupancy,
//   beat counts, done placement and the four-phase handshake.
module tb_arbiter_client;

  logic       clk = 1'b0;
  logic       reset;
  logic       job_valid;
  logic [3:0] job_len;
  logic       job_ready;
  logic       req;
  logic       ack;
  logic       beat;
  logic       done;
  logic [2:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  logic chk_en = 1'b0;
  logic prev_req, prev_ack, prev_done, prev_reset;

  arbiter_client #(.DEPTH(4), .LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .job_valid (job_valid),
    .job_len   (job_len),
    .job_ready (job_ready),
    .req       (req),
    .ack       (ack),
    .beat      (beat),
    .done      (done),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Continuous handshake watch, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (req && !prev_req) begin
        n_checks++;
        if (prev_ack) $display("FAIL hs_req_rise: req rose while ack=%b (required 0)", prev_ack);
        else n_pass++;
      end
      if (beat) begin
        n_checks++;
        if (!req) $display("FAIL hs_beat_req: beat=1 with req=%b (required 1)", req);
        else n_pass++;
      end
      if (done) begin
        n_checks++;
        if (!beat) $display("FAIL hs_done_beat: done=1 with beat=%b (required 1)", beat);
        else n_pass++;
      end
      if (!req && prev_req) begin
        n_checks++;
        if (!(prev_done || prev_reset))
          $display("FAIL hs_req_fall: req fell with done=%b reset=%b (required one of them 1)", prev_done, prev_reset);
        else n_pass++;
      end
    end
    prev_req   = req;
    prev_ack   = ack;
    prev_done  = done;
    prev_reset = reset;
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task reset_dut;
    reset     = 1'b1;
    ack       = 1'b0;
    job_valid = 1'b0;
    job_len   = 4'd0;
    tick();
    reset = 1'b0;
  endtask

  // Controller model for one job: wait for req, grant two edges later, then
  // record what the DUT shows during the hold. Leaves ack high on return.
  task automatic serve(output int nb, output int nd, output bit last_done, output bit got_req);
    nb = 0; nd = 0; last_done = 1'b0; got_req = 1'b0;
    for (int i = 0; i < 50 && !req; i++) tick();
    got_req = req;
    if (!got_req) return;
    tick();
    tick();
    ack = 1'b1;
    tick();
    for (int i = 0; i < 40 && beat; i++) begin
      nb++;
      if (done) nd++;
      last_done = done;
      tick();
    end
  endtask

  task test_reset;
    reset = 1'b1; ack = 1'b0; job_valid = 1'b0; job_len = 4'd0;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (req !== 1'b0) $display("FAIL rst_req: got %b need 0", req); else n_pass++;
    n_checks++; if (beat !== 1'b0) $display("FAIL rst_beat: got %b need 0", beat); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b need 0", done); else n_pass++;
    n_checks++; if (pending !== 3'd0) $display("FAIL rst_pending: got %0d need 0", pending); else n_pass++;
    n_checks++; if (job_ready !== 1'b1) $display("FAIL rst_job_ready: got %b need 1", job_ready); else n_pass++;
    chk_en = 1'b1;
  endtask

  task automatic test_single_job;
    int nb, nd; bit ld, gr;
    reset_dut();
    job_valid = 1'b1; job_len = 4'd2;
    tick();
    job_valid = 1'b0;
    n_checks++; if (pending !== 3'd1) $display("FAIL single_push_pending: got %0d need 1", pending); else n_pass++;
    n_checks++; if (req !== 1'b0) $display("FAIL single_req_early: got %b need 0", req); else n_pass++;
    tick();
    n_checks++; if (req !== 1'b1) $display("FAIL single_req_rise: got %b need 1", req); else n_pass++;
    n_checks++; if (pending !== 3'd0) $display("FAIL single_pop_pending: got %0d need 0", pending); else n_pass++;
    serve(nb, nd, ld, gr);
    n_checks++; if (gr !== 1'b1) $display("FAIL single_got_req: got %b need 1", gr); else n_pass++;
    n_checks++; if (nb != 3) $display("FAIL single_beats: got %0d need 3", nb); else n_pass++;
    n_checks++; if (nd != 1) $display("FAIL single_dones: got %0d need 1", nd); else n_pass++;
    n_checks++; if (ld !== 1'b1) $display("FAIL single_done_last: got %b need 1", ld); else n_pass++;
    n_checks++; if (req !== 1'b0) $display("FAIL single_req_low: got %b need 0", req); else n_pass++;
    // Next job must wait for ack to fall.
    job_valid = 1'b1; job_len = 4'd0;
    tick();
    job_valid = 1'b0;
    n_checks++; if (req !== 1'b0) $display("FAIL single_wait_ack1: got %b need 0", req); else n_pass++;
    n_checks++; if (pending !== 3'd1) $display("FAIL single_wait_pending: got %0d need 1", pending); else n_pass++;
    tick();
    n_checks++; if (req !== 1'b0) $display("FAIL single_wait_ack2: got %b need 0", req); else n_pass++;
    ack = 1'b0;
    tick();
    n_checks++; if (req !== 1'b0) $display("FAIL single_idle_gap: got %b need 0", req); else n_pass++;
    tick();
    n_checks++; if (req !== 1'b1) $display("FAIL single_next_req: got %b need 1", req); else n_pass++;
    serve(nb, nd, ld, gr);
    n_checks++; if (nb != 1) $display("FAIL single_next_beats: got %0d need 1", nb); else n_pass++;
    ack = 1'b0; tick(); tick();
  endtask

  task automatic test_fill_back_to_back;
    int nb, nd; bit ld, gr;
    reset_dut();
    job_valid = 1'b1; job_len = 4'd0;
    tick();
    job_len = 4'd1;
    tick();
    n_checks++; if (req !== 1'b1) $display("FAIL fill_first_req: got %b need 1", req); else n_pass++;
    n_checks++; if (pending !== 3'd1) $display("FAIL fill_pushpop_pending: got %0d need 1", pending); else n_pass++;
    job_len = 4'd2; tick();
    job_len = 4'd3; tick();
    job_len = 4'd4; tick();
    n_checks++; if (pending !== 3'd4) $display("FAIL fill_full_pending: got %0d need 4", pending); else n_pass++;
    n_checks++; if (job_ready !== 1'b0) $display("FAIL fill_full_ready: got %b need 0", job_ready); else n_pass++;
    job_len = 4'd9; tick();
    job_valid = 1'b0;
    n_checks++; if (pending !== 3'd4) $display("FAIL fill_blocked_pending: got %0d need 4", pending); else n_pass++;
    n_checks++; if (job_ready !== 1'b0) $display("FAIL fill_blocked_ready: got %b need 0", job_ready); else n_pass++;
    serve(nb, nd, ld, gr);
    n_checks++; if (nb != 1) $display("FAIL fill_job0_beats: got %0d need 1", nb); else n_pass++;
    n_checks++; if (nd != 1) $display("FAIL fill_job0_dones: got %0d need 1", nd); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      ack = 1'b0;
      tick(); tick();
      n_checks++; if (req !== 1'b1) $display("FAIL fill_req_job%0d: got %b need 1", k, req); else n_pass++;
      n_checks++; if (pending !== 3'(4 - k)) $display("FAIL fill_pending_job%0d: got %0d need %0d", k, pending, 4 - k); else n_pass++;
      serve(nb, nd, ld, gr);
      n_checks++; if (nb != k + 1) $display("FAIL fill_beats_job%0d: got %0d need %0d", k, nb, k + 1); else n_pass++;
      n_checks++; if (nd != 1 || ld !== 1'b1) $display("FAIL fill_done_job%0d: got %0d dones last=%b need 1 last=1", k, nd, ld); else n_pass++;
    end
    ack = 1'b0; tick(); tick();
    n_checks++; if (req !== 1'b0) $display("FAIL fill_drained_req: got %b need 0", req); else n_pass++;
  endtask

  task automatic test_simul_push_pop;
    int nb, nd; bit ld, gr;
    int exp_nb[3];
    exp_nb = '{2, 1, 7};
    reset_dut();
    // ack held high keeps the FSM in IDLE while the queue fills.
    ack = 1'b1; job_valid = 1'b1;
    job_len = 4'd3; tick();
    job_len = 4'd2; tick();
    job_len = 4'd1; tick();
    job_len = 4'd0; tick();
    n_checks++; if (pending !== 3'd4) $display("FAIL simul_fill_pending: got %0d need 4", pending); else n_pass++;
    n_checks++; if (req !== 1'b0) $display("FAIL simul_req_under_ack: got %b need 0", req); else n_pass++;
    // Push offered while full on the pop cycle is dropped.
    job_len = 4'd5; ack = 1'b0; tick();
    job_valid = 1'b0;
    n_checks++; if (pending !== 3'd3) $display("FAIL simul_full_pop_pending: got %0d need 3", pending); else n_pass++;
    n_checks++; if (req !== 1'b1) $display("FAIL simul_first_req: got %b need 1", req); else n_pass++;
    serve(nb, nd, ld, gr);
    n_checks++; if (nb != 4) $display("FAIL simul_beats_len3: got %0d need 4", nb); else n_pass++;
    ack = 1'b0; tick();
    job_valid = 1'b1; job_len = 4'd6; tick();
    job_valid = 1'b0;
    n_checks++; if (pending !== 3'd3) $display("FAIL simul_pushpop_pending: got %0d need 3", pending); else n_pass++;
    n_checks++; if (req !== 1'b1) $display("FAIL simul_pushpop_req: got %b need 1", req); else n_pass++;
    serve(nb, nd, ld, gr);
    n_checks++; if (nb != 3) $display("FAIL simul_beats_len2: got %0d need 3", nb); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      ack = 1'b0;
      tick(); tick();
      n_checks++; if (pending !== 3'(2 - k)) $display("FAIL simul_pending_%0d: got %0d need %0d", k, pending, 2 - k); else n_pass++;
      serve(nb, nd, ld, gr);
      n_checks++; if (nb != exp_nb[k]) $display("FAIL simul_order_%0d: got %0d beats need %0d", k, nb, exp_nb[k]); else n_pass++;
    end
    ack = 1'b0; tick(); tick();
  endtask

  task automatic test_max_len;
    int nb, nd; bit ld, gr;
    reset_dut();
    job_valid = 1'b1; job_len = 4'd15; tick();
    job_valid = 1'b0;
    serve(nb, nd, ld, gr);
    n_checks++; if (nb != 16) $display("FAIL max_beats: got %0d need 16", nb); else n_pass++;
    n_checks++; if (nd != 1) $display("FAIL max_dones: got %0d need 1", nd); else n_pass++;
    n_checks++; if (ld !== 1'b1) $display("FAIL max_done_last: got %b need 1", ld); else n_pass++;
    ack = 1'b0; tick(); tick(); tick();
    n_checks++; if (req !== 1'b0) $display("FAIL max_no_restart_req: got %b need 0", req); else n_pass++;
    n_checks++; if (beat !== 1'b0) $display("FAIL max_no_extra_beat: got %b need 0", beat); else n_pass++;
  endtask

  task automatic test_reset_in_hold;
    int nb, nd; bit ld, gr;
    reset_dut();
    job_valid = 1'b1;
    job_len = 4'd5; tick();
    job_len = 4'd1; tick();
    job_len = 4'd2; tick();
    job_valid = 1'b0;
    n_checks++; if (pending !== 3'd2) $display("FAIL rsthold_pending: got %0d need 2", pending); else n_pass++;
    tick();
    ack = 1'b1; tick();
    n_checks++; if (beat !== 1'b1) $display("FAIL rsthold_in_hold: beat=%b need 1", beat); else n_pass++;
    tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    n_checks++; if (req !== 1'b0) $display("FAIL rsthold_req: got %b need 0", req); else n_pass++;
    n_checks++; if (pending !== 3'd0) $display("FAIL rsthold_pending_clr: got %0d need 0", pending); else n_pass++;
    n_checks++; if (beat !== 1'b0 || done !== 1'b0) $display("FAIL rsthold_beat_done: beat=%b done=%b need 0 0", beat, done); else n_pass++;
    job_valid = 1'b1; job_len = 4'd0; tick();
    job_valid = 1'b0;
    n_checks++; if (req !== 1'b0) $display("FAIL rsthold_req_ack1_a: got %b need 0", req); else n_pass++;
    n_checks++; if (pending !== 3'd1) $display("FAIL rsthold_queued: got %0d need 1", pending); else n_pass++;
    tick();
    n_checks++; if (req !== 1'b0) $display("FAIL rsthold_req_ack1_b: got %b need 0", req); else n_pass++;
    ack = 1'b0; tick();
    n_checks++; if (req !== 1'b1) $display("FAIL rsthold_req_after_ack0: got %b need 1", req); else n_pass++;
    serve(nb, nd, ld, gr);
    n_checks++; if (nb != 1 || nd != 1) $display("FAIL rsthold_job: got %0d beats %0d dones need 1 1", nb, nd); else n_pass++;
    ack = 1'b0; tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_fill_back_to_back();
    test_simul_push_pop();
    test_max_len();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
